// File: rtl/systolic_feeder.sv
// systolic_feeder: collects four weight columns and four data rows, then
// drives a 4x4 systolic array through weight load, a skewed data feed,
// a drain window and a one-cycle done pulse.
module systolic_feeder #(
  parameter int DRAIN_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        control,
  output logic [31:0] wt_arr,
  output logic [31:0] data_arr,
  output logic        data_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    WLOAD   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  wcnt_r;
  logic [2:0]  wcnt_s;
  logic [7:0]  phase_r;
  logic [7:0]  phase_s;
  logic [31:0] w_r [4];
  logic [31:0] d_r [4];
  logic        accept_s;
  logic [127:0] rows_s;
  logic        control_s;
  logic [31:0] wt_s;
  logic [31:0] data_s;
  logic        data_valid_s;
  logic        done_s;

  // Lane k carries byte (t-k) of row k while that index is inside the row.
  function automatic logic [31:0] skew_word(input logic [7:0] t, input logic [127:0] rows);
    logic [31:0] w;
    int          idx;
    w = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      idx = int'(t) - k;
      if (idx >= 0 && idx <= 3) begin
        w[8*k +: 8] = rows[32*k + 8*idx +: 8];
      end else begin
        w[8*k +: 8] = 8'h00;
      end
    end
    return w;
  endfunction

  assign in_ready = (state_r == COLLECT);
  assign busy     = (state_r != COLLECT);
  assign accept_s = in_valid && in_ready;
  assign rows_s   = {d_r[3], d_r[2], d_r[1], d_r[0]};

  // Next-state, word-count and phase-counter logic.
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    phase_s = phase_r;
    case (state_r)
      COLLECT: begin
        if (accept_s) begin
          if (wcnt_r == 3'd7) begin
            state_s = WLOAD;
            wcnt_s  = 3'd0;
            phase_s = 8'd0;
          end else begin
            wcnt_s = wcnt_r + 3'd1;
          end
        end else begin
          wcnt_s = wcnt_r;
        end
      end
      WLOAD: begin
        if (phase_r == 8'd3) begin
          state_s = FEED;
          phase_s = 8'd0;
        end else begin
          phase_s = phase_r + 8'd1;
        end
      end
      FEED: begin
        if (phase_r == 8'd6) begin
          state_s = (DRAIN_CYC == 0) ? DONE : DRAIN;
          phase_s = 8'd0;
        end else begin
          phase_s = phase_r + 8'd1;
        end
      end
      DRAIN: begin
        if (phase_r == DRAIN_LAST) begin
          state_s = DONE;
          phase_s = 8'd0;
        end else begin
          phase_s = phase_r + 8'd1;
        end
      end
      DONE: begin
        state_s = COLLECT;
        wcnt_s  = 3'd0;
        phase_s = 8'd0;
      end
      default: begin
        state_s = COLLECT;
        wcnt_s  = 3'd0;
        phase_s = 8'd0;
      end
    endcase
  end

  // Output values for the upcoming state, so the registered outputs line up with it.
  always_comb begin
    control_s    = 1'b0;
    wt_s         = 32'h0000_0000;
    data_s       = 32'h0000_0000;
    data_valid_s = 1'b0;
    done_s       = 1'b0;
    case (state_s)
      WLOAD: begin
        control_s = 1'b1;
        wt_s      = w_r[phase_s[1:0]];
      end
      FEED: begin
        data_s       = skew_word(phase_s, rows_s);
        data_valid_s = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        control_s = 1'b0;
      end
    endcase
  end

  // State, buffer and output registers; reset aborts any job and clears the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= COLLECT;
      wcnt_r     <= 3'd0;
      phase_r    <= 8'd0;
      control    <= 1'b0;
      wt_arr     <= 32'h0000_0000;
      data_arr   <= 32'h0000_0000;
      data_valid <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        w_r[i] <= 32'h0000_0000;
        d_r[i] <= 32'h0000_0000;
      end
    end else begin
      state_r    <= state_s;
      wcnt_r     <= wcnt_s;
      phase_r    <= phase_s;
      control    <= control_s;
      wt_arr     <= wt_s;
      data_arr   <= data_s;
      data_valid <= data_valid_s;
      done       <= done_s;
      if (accept_s) begin
        if (wcnt_r[2]) begin
          d_r[wcnt_r[1:0]] <= in_data;
        end else begin
          w_r[wcnt_r[1:0]] <= in_data;
        end
      end
    end
  end

endmodule
